// File: rtl/cpu_defs.sv
// Shared definitions for the execute-stage iterative divider.
package cpu_defs;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Result signs captured with the request, applied once the magnitudes are done.
  typedef struct packed {
    logic q_neg;
    logic r_neg;
  } div_sign_t;

endpackage

// File: rtl/div_sched_if.sv
// Execute-stage <-> divider handshake: request/operands in, stall and results out.
interface div_sched_if #(
  parameter int DATA_W = 32
);

  logic              es_div_req;
  logic              es_div_signed;
  logic [DATA_W-1:0] es_src1;
  logic [DATA_W-1:0] es_src2;
  logic              es_adv;
  logic              exc_flush;
  logic              div_block;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  // Pipeline side: issues requests, consumes stall and results.
  modport master (
    output es_div_req, es_div_signed, es_src1, es_src2, es_adv, exc_flush,
    input  div_block, div_busy, div_done, div_q, div_r
  );

  // Divider side.
  modport slave (
    input  es_div_req, es_div_signed, es_src1, es_src2, es_adv, exc_flush,
    output div_block, div_busy, div_done, div_q, div_r
  );

endinterface

// File: rtl/div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, shift the outcome into the quotient.
module div_iter #(
  parameter int DATA_W = cpu_defs::DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] dvs_ext;
  logic            fits;

  // Trial subtraction and selection of the restored or reduced remainder.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    dvs_ext = {1'b0, dvs_i};
    fits    = (shifted >= dvs_ext);
    // A reduced remainder is always below the divisor, so truncation is exact.
    rem_o   = fits ? DATA_W'(shifted - dvs_ext) : shifted[DATA_W-1:0];
    quo_o   = {quo_i[DATA_W-2:0], fits};
  end

endmodule

// File: rtl/div_sched.sv
// Sequencing controller for the one-bit-per-cycle 32-bit divider in es.
// Runs unsigned magnitudes through div_iter for DATA_W cycles, then applies
// the latched signs and holds the result for HI/LO writeback.
// CNT_W must satisfy 2**CNT_W > DATA_W.
module div_sched #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int CNT_W  = cpu_defs::CNT_W
) (
  input  logic        clk,
  input  logic        resetn,
  div_sched_if.slave  bus
);

  import cpu_defs::*;

  div_state_t        state_q;
  div_state_t        state_d;
  logic              accept;
  logic              finish;
  logic              last_step;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  div_sign_t         sign_q;

  logic [DATA_W-1:0] rem_n;
  logic [DATA_W-1:0] quo_n;
  logic [DATA_W-1:0] src1_mag;
  logic [DATA_W-1:0] src2_mag;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] r_reg;

  div_iter #(.DATA_W(DATA_W)) u_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  // Operand magnitudes; only a signed request with a set MSB is negated.
  // The most negative value negates to itself, which is its correct magnitude.
  assign src1_mag = (bus.es_div_signed && bus.es_src1[DATA_W-1]) ? -bus.es_src1 : bus.es_src1;
  assign src2_mag = (bus.es_div_signed && bus.es_src2[DATA_W-1]) ? -bus.es_src2 : bus.es_src2;

  assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

  // Sign correction of the final step. With a zero divisor the quotient is
  // all ones unsigned-style; negating the remainder magnitude by the dividend
  // sign then reproduces the raw dividend, which is the required remainder.
  assign q_fix = (dvs_q == '0) ? '1 : (sign_q.q_neg ? -quo_n : quo_n);
  assign r_fix = sign_q.r_neg ? -rem_n : rem_n;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a flush overrides everything and returns to IDLE.
  always_comb begin
    // NOTE: every combinationally driven signal gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    if (bus.exc_flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: if (bus.es_div_req) begin
          state_d = DIV_BUSY;
          accept  = 1'b1;
        end
        DIV_BUSY: if (last_step) begin
          state_d = DIV_DONE;
          finish  = 1'b1;
        end
        DIV_DONE: if (bus.es_adv) state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  // Operand capture on accept, one restoring step per BUSY cycle, result
  // registration on the final step.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: the datapath registers are reset too, so results read back as
    // zero after reset and no X can leak into writeback.
    if (!resetn) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      sign_q <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
    end else if (accept) begin
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= src1_mag;
      dvs_q        <= src2_mag;
      sign_q.q_neg <= bus.es_div_signed & (bus.es_src1[DATA_W-1] ^ bus.es_src2[DATA_W-1]);
      sign_q.r_neg <= bus.es_div_signed & bus.es_src1[DATA_W-1];
    end else if (state_q == DIV_BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (finish) begin
        q_reg <= q_fix;
        r_reg <= r_fix;
      end
    end
  end

  // Status and stall; the stall drops in DONE so es can leave with the result.
  assign bus.div_busy  = (state_q == DIV_BUSY);
  assign bus.div_done  = (state_q == DIV_DONE);
  assign bus.div_block = bus.es_div_req & ~bus.exc_flush & (state_q != DIV_DONE);
  assign bus.div_q     = q_reg;
  assign bus.div_r     = r_reg;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed corner cases plus random
// divisions checked against a plain-arithmetic reference and cycle timing.
module tb_div_sched;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  div_sched_if #(.DATA_W(32)) bus ();

  div_sched #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result from integer arithmetic: truncating division, remainder
  // takes the dividend sign, zero divisor gives all-ones / raw dividend.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    longint      sa;
    longint      sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // One division issued at cycle c=0 with the request held until it leaves es.
  // flush_at / reset_at (>=0) abort at that cycle; done_wait extra DONE cycles
  // pass before es_adv. Inputs are driven #1 after posedge, outputs read at negedge.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int reset_at, input int done_wait);
    logic [63:0] exp_qr;
    exp_qr = ref_div(sgn, a, b);
    for (int c = 0; c <= 33 + done_wait; c++) begin
      @(posedge clk); #1;
      bus.es_div_req    = 1'b1;
      bus.es_div_signed = sgn;
      bus.es_src1       = a;
      bus.es_src2       = b;
      bus.es_adv        = 1'b0;
      bus.exc_flush     = (c == flush_at);
      if (c == reset_at) begin
        bus.es_div_req = 1'b0;
        resetn         = 1'b0;
      end
      @(negedge clk);
      if (c == reset_at) begin
        check("rst_block", 32'(bus.div_block), 32'd0);
        check("rst_busy",  32'(bus.div_busy),  32'd0);
        check("rst_done",  32'(bus.div_done),  32'd0);
        check("rst_q",     bus.div_q, 32'd0);
        check("rst_r",     bus.div_r, 32'd0);
        resetn = 1'b1;
        return;
      end
      if (c == flush_at) begin
        check("flush_block", 32'(bus.div_block), 32'd0);
        check("flush_busy",  32'(bus.div_busy),  32'((c >= 1) && (c <= 32)));
        check("flush_done",  32'(bus.div_done),  32'(c >= 33));
        return;
      end
      check("block", 32'(bus.div_block), 32'(c <= 32));
      check("busy",  32'(bus.div_busy),  32'((c >= 1) && (c <= 32)));
      check("done",  32'(bus.div_done),  32'(c >= 33));
      if (c >= 33) begin
        check("q", bus.div_q, exp_qr[63:32]);
        check("r", bus.div_r, exp_qr[31:0]);
      end
      if (c == 33 + done_wait) bus.es_adv = 1'b1;
    end
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    resetn            = 1'b0;
    bus.es_div_req    = 1'b0;
    bus.es_div_signed = 1'b0;
    bus.es_src1       = '0;
    bus.es_src2       = '0;
    bus.es_adv        = 1'b0;
    bus.exc_flush     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_block", 32'(bus.div_block), 32'd0);
    check("reset_busy",  32'(bus.div_busy),  32'd0);
    check("reset_done",  32'(bus.div_done),  32'd0);
    check("reset_q",     bus.div_q, 32'd0);
    check("reset_r",     bus.div_r, 32'd0);
    resetn = 1'b1;

    // Basic unsigned and signed cases, overflow pair and zero divisors.
    run_div(1'b0, 32'd100,        32'd7,        -1, -1, 0);
    run_div(1'b1, 32'hFFFF_FFF9,  32'd2,        -1, -1, 0);
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, -1, -1, 1);
    run_div(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, -1, -1, 0);
    run_div(1'b0, 32'h0000_1234,  32'd0,        -1, -1, 0);
    run_div(1'b1, 32'hFFFF_FFFB,  32'd0,        -1, -1, 2);

    // Flush mid-BUSY, then a request in the very next cycle.
    run_div(1'b0, 32'd1000,       32'd3,        10, -1, 0);
    run_div(1'b0, 32'd9,          32'd4,        -1, -1, 0);

    // Flush coinciding with the request, and flush while DONE.
    run_div(1'b1, 32'hFFFF_FF00,  32'd7,         0, -1, 0);
    run_div(1'b0, 32'd77,         32'd5,        34, -1, 2);

    // Reset mid-BUSY, then back-to-back divides.
    run_div(1'b0, 32'd77,         32'd3,        -1,  5, 0);
    run_div(1'b0, 32'd50,         32'd5,        -1, -1, 0);
    run_div(1'b0, 32'd51,         32'd5,        -1, -1, 0);

    // Random divisions with occasional flushes and DONE dwell.
    for (int i = 0; i < 24; i++) begin
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      int          fl;
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 34)) : -1;
      run_div(sgn, a, b, fl, -1, int'($urandom_range(0, 2)));
    end

    @(posedge clk); #1;
    bus.es_div_req = 1'b0;
    bus.es_adv     = 1'b0;
    bus.exc_flush  = 1'b0;
    @(negedge clk);
    check("end_busy", 32'(bus.div_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
